// File: rtl/sv32_walk_arbiter_pkg.sv
// Shared definitions for the Sv32 walker arbiter: FSM states, side
// constants and the two-input round-robin picker.
package sv32_walk_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_DRAIN = 2'd3
  } walk_state_e;

  localparam logic SV32_WALK_SIDE_I = 1'b0;
  localparam logic SV32_WALK_SIDE_D = 1'b1;

  // Returns the winning side; the side not granted last wins a tie, and
  // before any grant the static preference decides.
  function automatic logic pick_side(input logic i_req, input logic d_req,
                                     input logic granted_once,
                                     input logic last_side,
                                     input logic first_side);
    logic side;
    if (i_req && d_req) begin
      side = granted_once ? ~last_side : first_side;
    end else if (d_req) begin
      side = SV32_WALK_SIDE_D;
    end else begin
      side = SV32_WALK_SIDE_I;
    end
    return side;
  endfunction

endpackage

// File: rtl/sv32_walk_arbiter.sv
// Grants the single Sv32 page-table walker to the instruction or data
// translator with round-robin fairness and a lock for the walk duration.
module sv32_walk_arbiter
  import sv32_walk_arbiter_pkg::*;
#(
  parameter logic DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_walk_valid,
  input  logic [31:0] i_address,
  output logic        i_walk_ready,
  output logic [31:0] i_pte,
  input  logic        d_walk_valid,
  input  logic [31:0] d_address,
  output logic        d_walk_ready,
  output logic [31:0] d_pte,
  output logic        walk_valid,
  output logic [31:0] walk_address,
  input  logic        walk_ready,
  input  logic [31:0] walk_pte,
  input  logic        hold,
  output logic        walker_idle,
  output logic        grant_data
);

  walk_state_e state;
  logic        last_side;
  logic        granted_once;
  logic [31:0] latched_address;
  logic        new_side;

  assign new_side = pick_side(i_walk_valid, d_walk_valid, granted_once,
                              last_side, DATA_FIRST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      last_side       <= DATA_FIRST;
      granted_once    <= 1'b0;
      latched_address <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!hold && (i_walk_valid || d_walk_valid)) begin
            state           <= (new_side == SV32_WALK_SIDE_D) ? ST_GNT_D : ST_GNT_I;
            latched_address <= (new_side == SV32_WALK_SIDE_D) ? d_address : i_address;
            last_side       <= new_side;
            granted_once    <= 1'b1;
          end
        end
        ST_GNT_I: begin
          if (walk_ready) begin
            if (!hold && d_walk_valid) begin
              state           <= ST_GNT_D;
              latched_address <= d_address;
              last_side       <= SV32_WALK_SIDE_D;
              granted_once    <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else if (!i_walk_valid) begin
            state           <= ST_DRAIN;
            latched_address <= i_address;
          end
        end
        ST_GNT_D: begin
          if (walk_ready) begin
            if (!hold && i_walk_valid) begin
              state           <= ST_GNT_I;
              latched_address <= i_address;
              last_side       <= SV32_WALK_SIDE_I;
              granted_once    <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else if (!d_walk_valid) begin
            state           <= ST_DRAIN;
            latched_address <= d_address;
          end
        end
        ST_DRAIN: begin
          // The walker must finish the orphaned walk before anyone else gets it.
          if (walk_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    walk_valid   = 1'b0;
    walk_address = 32'd0;
    i_walk_ready = 1'b0;
    i_pte        = 32'd0;
    d_walk_ready = 1'b0;
    d_pte        = 32'd0;
    case (state)
      ST_GNT_I: begin
        walk_valid   = 1'b1;
        walk_address = i_address;
        i_walk_ready = walk_ready;
        i_pte        = walk_pte;
      end
      ST_GNT_D: begin
        walk_valid   = 1'b1;
        walk_address = d_address;
        d_walk_ready = walk_ready;
        d_pte        = walk_pte;
      end
      ST_DRAIN: begin
        walk_valid   = 1'b1;
        walk_address = latched_address;
      end
      default: ;
    endcase
  end

  assign walker_idle = (state == ST_IDLE);
  assign grant_data  = last_side;

endmodule

// File: tb/tb_sv32_walk_arbiter.sv
// Bench for sv32_walk_arbiter: directed scenarios then randomized traffic,
// all compared against an ownership-based reference model.
module tb_sv32_walk_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_walk_valid, d_walk_valid;
  logic [31:0] i_address, d_address;
  logic        i_walk_ready, d_walk_ready;
  logic [31:0] i_pte, d_pte;
  logic        walk_valid;
  logic [31:0] walk_address;
  logic        walk_ready;
  logic [31:0] walk_pte;
  logic        hold;
  logic        walker_idle;
  logic        grant_data;

  always #5 clk = ~clk;

  sv32_walk_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_walk_valid(i_walk_valid), .i_address(i_address),
    .i_walk_ready(i_walk_ready), .i_pte(i_pte),
    .d_walk_valid(d_walk_valid), .d_address(d_address),
    .d_walk_ready(d_walk_ready), .d_pte(d_pte),
    .walk_valid(walk_valid), .walk_address(walk_address),
    .walk_ready(walk_ready), .walk_pte(walk_pte),
    .hold(hold), .walker_idle(walker_idle), .grant_data(grant_data)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the walker (-1 nobody, 0 instr, 1 data, 2 orphan).
  int          m_owner;
  bit          m_last_data;
  bit          m_granted;
  logic [31:0] m_orphan_addr;
  logic        e_ir, e_dr;

  task automatic modelReset();
    m_owner       = -1;
    m_last_data   = 1'b1;
    m_granted     = 1'b0;
    m_orphan_addr = 32'd0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, checks outputs mid-cycle, then advances the model.
  task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                               input logic dv, input logic [31:0] da,
                               input logic h, input logic wr,
                               input logic [31:0] wp, input logic rst);
    logic [31:0] e_wa;
    bit pick_data;
    i_walk_valid = iv; i_address = ia;
    d_walk_valid = dv; d_address = da;
    hold = h; walk_ready = wr; walk_pte = wp; reset = rst;
    #4;
    e_wa = (m_owner == 0) ? ia : (m_owner == 1) ? da :
           (m_owner == 2) ? m_orphan_addr : 32'd0;
    e_ir = (m_owner == 0) && wr;
    e_dr = (m_owner == 1) && wr;
    checkOutput("walk_valid", {31'd0, walk_valid}, {31'd0, m_owner != -1});
    checkOutput("walk_address", walk_address, e_wa);
    checkOutput("i_walk_ready", {31'd0, i_walk_ready}, {31'd0, e_ir});
    checkOutput("d_walk_ready", {31'd0, d_walk_ready}, {31'd0, e_dr});
    checkOutput("i_pte", i_pte, (m_owner == 0) ? wp : 32'd0);
    checkOutput("d_pte", d_pte, (m_owner == 1) ? wp : 32'd0);
    checkOutput("walker_idle", {31'd0, walker_idle}, {31'd0, m_owner == -1});
    checkOutput("grant_data", {31'd0, grant_data}, {31'd0, m_last_data});
    if (rst) begin
      modelReset();
    end else if (m_owner == -1) begin
      if (!h && (iv || dv)) begin
        pick_data   = (iv && dv) ? (m_granted ? !m_last_data : 1'b1) : dv;
        m_owner     = pick_data ? 1 : 0;
        m_last_data = pick_data;
        m_granted   = 1'b1;
      end
    end else if (m_owner == 2) begin
      if (wr) m_owner = -1;
    end else begin
      if (wr) begin
        if (!h && ((m_owner == 0) ? dv : iv)) begin
          m_owner     = 1 - m_owner;
          m_last_data = (m_owner == 1);
        end else begin
          m_owner = -1;
        end
      end else if (!((m_owner == 0) ? iv : dv)) begin
        m_orphan_addr = (m_owner == 0) ? ia : da;
        m_owner       = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic        rv_i, rv_d;
  logic [31:0] ra_i, ra_d;

  initial begin
    reset = 1'b1; hold = 1'b0; walk_ready = 1'b0; walk_pte = 32'd0;
    i_walk_valid = 1'b0; i_address = 32'd0;
    d_walk_valid = 1'b0; d_address = 32'd0;
    @(posedge clk);
    #1;
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Lone instruction request with a three-cycle walk.
    applyStimulus(1, 32'h4000_1234, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h4000_1234, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h4000_1234, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h4000_1234, 0, 0, 0, 1, 32'h2000_00CF, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Simultaneous requests from reset, direct handover, then a second pair.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 32'h1111_0000, 1, 32'h2222_0000, 0, 0, 0, 0);
    applyStimulus(1, 32'h1111_0000, 1, 32'h2222_0000, 0, 1, 32'hAAAA_0001, 0);
    applyStimulus(1, 32'h1111_0000, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h1111_0000, 0, 0, 0, 1, 32'hBBBB_0002, 0);
    applyStimulus(1, 32'h1111_4000, 1, 32'h2222_4000, 0, 0, 0, 0);
    applyStimulus(1, 32'h1111_4000, 1, 32'h2222_4000, 0, 1, 32'hCCCC_0003, 0);

    // Withdrawn data request goes through DRAIN.
    applyStimulus(1, 32'h1111_4000, 0, 0, 0, 1, 32'hDDDD_0004, 0);
    applyStimulus(0, 0, 1, 32'h3333_8000, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h3333_8000, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h3333_8000, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 32'hEEEE_0005, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // hold blocks grants, lets an active walk finish, then releases.
    applyStimulus(1, 32'h5555_0000, 1, 32'h6666_0000, 1, 0, 0, 0);
    applyStimulus(1, 32'h5555_0000, 1, 32'h6666_0000, 1, 0, 0, 0);
    applyStimulus(1, 32'h5555_0000, 1, 32'h6666_0000, 0, 0, 0, 0);
    applyStimulus(1, 32'h5555_0000, 1, 32'h6666_0000, 1, 0, 0, 0);
    applyStimulus(1, 32'h5555_0000, 1, 32'h6666_0000, 1, 1, 32'h1234_5678, 0);
    applyStimulus(1, 32'h5555_0000, 1, 32'h6666_0000, 0, 0, 0, 0);

    // Reset in the middle of an instruction walk.
    applyStimulus(1, 32'h5555_0000, 1, 32'h6666_0000, 0, 0, 0, 1);
    applyStimulus(1, 32'h7777_0000, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h7777_0000, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic obeying the translator protocol.
    rv_i = 0; rv_d = 0; ra_i = 0; ra_d = 0;
    for (int n = 0; n < 3000; n++) begin
      logic wr;
      wr = (m_owner != -1) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 10);
      applyStimulus(rv_i, ra_i, rv_d, ra_d, $urandom_range(0, 99) < 15, wr,
                    $urandom, $urandom_range(0, 999) < 8);
      if (rv_i && e_ir) begin
        rv_i = $urandom_range(0, 1);
        ra_i = $urandom;
      end else if (rv_i && m_owner == 0 && $urandom_range(0, 99) < 3) begin
        rv_i = 1'b0;
      end else if (!rv_i && $urandom_range(0, 99) < 30) begin
        rv_i = 1'b1;
        ra_i = $urandom;
      end
      if (rv_d && e_dr) begin
        rv_d = ($urandom_range(0, 99) < 70);
        ra_d = $urandom;
      end else if (rv_d && m_owner == 1 && $urandom_range(0, 99) < 3) begin
        rv_d = 1'b0;
      end else if (!rv_d && $urandom_range(0, 99) < 60) begin
        rv_d = 1'b1;
        ra_d = $urandom;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
